// File: rtl/rst_sequencer.sv
// rst_sequencer: staged reset release for NUM_DOMAINS downstream domains.
// Domain 0 (memory/peripherals) releases first. Domain 1 (core) waits for
// memory init, or for a timeout. Higher domains follow at fixed gaps.
// A software warm reset replays the staged release without re-running the
// input synchronizer.
module rst_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_GAP    = 4,
  parameter int NUM_DOMAINS  = 3,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   sw_reset_req,
  input  logic                   mem_init_done,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   seq_done,
  output logic [1:0]             reset_cause,
  output logic                   init_timeout
);

  // Counter widths. Each counter only ever needs to reach its terminal
  // value, so it saturates or is reloaded and never wraps.
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);
  localparam int TO_W   = $clog2(INIT_TIMEOUT + 1);
  localparam int IDX_W  = $clog2(NUM_DOMAINS);

  // Terminal values. A counter holding VALUE-1 on an edge means this edge
  // is the VALUE-th edge counted, so the action fires on that edge.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(INIT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0]  IDX_FIRST_REL = IDX_W'(2);

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_INIT = 2'd1,
    ST_REL       = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst_n;

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0]       dom_idx_q, dom_idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic [1:0]             cause_q, cause_d;
  logic                   tmo_q, tmo_d;

  logic                   gap_elapsed;
  logic                   hold_elapsed;
  logic                   init_expired;

  // Deassertion synchronizer: shifts in ones after resetn rises; its last
  // stage lets the sequencer start counting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

  assign hold_elapsed = (hold_cnt_q >= HOLD_LAST);
  assign gap_elapsed  = (gap_cnt_q >= GAP_LAST);
  assign init_expired = (to_cnt_q >= TO_LAST);

  // State, counters and all outputs are registered here; resetn clears
  // them asynchronously so domain resets assert without a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      to_cnt_q   <= '0;
      dom_idx_q  <= '0;
      rst_q      <= '0;
      done_q     <= 1'b0;
      cause_q    <= CAUSE_POR;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dom_idx_q  <= dom_idx_d;
      rst_q      <= rst_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state logic: HOLD counts out the hold period, WAIT_INIT releases
  // the core on init-done or timeout, REL walks the remaining domains,
  // RUN waits for a software warm reset.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    to_cnt_d   = to_cnt_q;
    dom_idx_d  = dom_idx_q;
    rst_d      = rst_q;
    done_d     = done_q;
    cause_d    = cause_q;
    tmo_d      = tmo_q;

    case (state_q)
      ST_HOLD: begin
        if (sync_rst_n) begin
          if (hold_elapsed) begin
            rst_d[0]   = 1'b1;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            to_cnt_d   = '0;
            state_d    = ST_WAIT_INIT;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      ST_WAIT_INIT: begin
        if ((gap_elapsed && mem_init_done) || init_expired) begin
          rst_d[1]  = 1'b1;
          gap_cnt_d = '0;
          if (!(gap_elapsed && mem_init_done)) begin
            tmo_d = 1'b1;
          end
          if (NUM_DOMAINS == 2) begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            dom_idx_d = IDX_FIRST_REL;
            state_d   = ST_REL;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (!gap_elapsed) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      ST_REL: begin
        if (gap_elapsed) begin
          for (int i = 2; i < NUM_DOMAINS; i++) begin
            if (dom_idx_q == IDX_W'(i)) begin
              rst_d[i] = 1'b1;
            end
          end
          gap_cnt_d = '0;
          if (dom_idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            dom_idx_d = dom_idx_q + 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (sw_reset_req) begin
          rst_d      = '0;
          done_d     = 1'b0;
          cause_d    = CAUSE_SW;
          tmo_d      = 1'b0;
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
          to_cnt_d   = '0;
          dom_idx_d  = '0;
          state_d    = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  assign rst_n_o      = rst_q;
  assign seq_done     = done_q;
  assign reset_cause  = cause_q;
  assign init_timeout = tmo_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumes the board-level clock and active-low reset produced by the clock/reset front end.
- Generates staged, synchronously released resets for NUM_DOMAINS downstream domains. Domain 0 is memory/peripherals, domain 1 is the core, higher domains are optional.
- Gates core release on memory-init completion, with a timeout.
- Supports a software-requested warm reset and reports the reset cause.

Parameters:
- SYNC_STAGES, 2, depth of the resetn deassertion synchronizer (>=2).
- HOLD_CYCLES, 16, cycles all domains stay in reset after the synchronized deassert (>=1).
- STAGE_GAP, 4, minimum cycles between consecutive domain releases (>=1).
- NUM_DOMAINS, 3, number of reset outputs (>=2).
- INIT_TIMEOUT, 1024, maximum cycles to wait for mem_init_done after domain 0 release (>STAGE_GAP).

Ports:
- clk  input  1  design clock
- resetn  input  1  asynchronous active-low reset
- sw_reset_req  input  1  synchronous one-cycle warm-reset request from the core
- mem_init_done  input  1  synchronous level, high when memory init is complete
- rst_n_o  output  NUM_DOMAINS  per-domain active-low resets
- seq_done  output  1  high while all domains are released
- reset_cause  output  2  01 = pin/POR, 10 = software, 00/11 unused
- init_timeout  output  1  sticky; high if the last sequence released domain 1 on timeout

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, named resetn. Every flop, including the synchronizer, is cleared asynchronously by resetn low.
- Reset values:
  - rst_n_o = 0
  - seq_done = 0
  - reset_cause = 01
  - init_timeout = 0
  - FSM = HOLD, counters = 0
- Assertion is asynchronous: rst_n_o falls immediately with resetn, without waiting for a clock edge.
- Synchronizer: a SYNC_STAGES-flop chain shifts in 1. Its last stage gates the FSM.
- Edge numbering: edge 1 is the first rising clk edge with resetn high. The synchronized reset is high after edge SYNC_STAGES.
- HOLD state:
  - The counter increments on each edge while the synchronized reset is high.
  - When it reaches HOLD_CYCLES, set rst_n_o[0]=1 on that edge.
  - Go to WAIT_INIT, and load the gap counter and the timeout counter.
  - Domain 0 release edge = SYNC_STAGES + HOLD_CYCLES (default edge 18).
- WAIT_INIT state (target domain 1):
  - Release domain 1 on the first edge where the gap has elapsed (>= STAGE_GAP cycles since domain 0 release) and mem_init_done is sampled high.
  - If mem_init_done has not been seen by edge (domain 0 release + INIT_TIMEOUT), set init_timeout=1 and release domain 1 on that edge anyway.
  - mem_init_done already high on entry means no additional delay beyond STAGE_GAP.
- REL state:
  - Domains 2..NUM_DOMAINS-1 each release exactly STAGE_GAP edges after the previous domain, in index order.
  - A released domain never reasserts except through resetn or a software reset.
- RUN state:
  - seq_done=1 on the same edge the last domain releases.
  - Stays in RUN until a reset event.
- Software reset:
  - sw_reset_req sampled high in RUN drops all rst_n_o to 0 on that edge.
  - Same edge: seq_done=0, reset_cause=10, init_timeout=0. Re-enter HOLD.
  - Domain 0 releases HOLD_CYCLES edges later; the synchronizer is not re-run.
  - sw_reset_req in any state other than RUN is ignored.
- resetn low at any point, including mid-sequence or mid-timeout, aborts immediately to reset values (cause=01). The full sequence restarts after deassert.
- Counter widths are sized with $clog2 of the largest count plus 1. Counters do not wrap; they saturate or are reloaded per state.
- Outputs come directly from flops, with no combinational path from inputs.
- reset_cause and init_timeout hold their value until the next reset event.

Test Plan:
- POR, defaults, mem_init_done tied 1:
  - Release resetn before edge 1.
  - rst_n_o[0] rises at edge 18, [1] at 22, [2] at 26.
  - seq_done=1 at 26; reset_cause=01; init_timeout=0.
- Delayed init (INIT_TIMEOUT=64):
  - mem_init_done rises just before edge 40.
  - rst_n_o[1] rises at edge 40, [2] at 44; init_timeout=0.
- Init timeout (INIT_TIMEOUT=64, mem_init_done held 0):
  - rst_n_o[1] rises at edge 82 with init_timeout=1.
  - rst_n_o[2] rises at 86; seq_done=1 at 86.
- Software reset: one-cycle sw_reset_req at edge S=100 in RUN.
  - All rst_n_o=0 and seq_done=0 after edge 100; reset_cause=10.
  - Domains release at edges 116, 120, 124.
  - sw_reset_req pulsed at edge 110 (during HOLD) has no effect.
- Reset mid-sequence: drop resetn between edges 20 and 21 (domain 0 released).
  - rst_n_o goes to 000 asynchronously, before the next edge; reset_cause=01.
  - After re-release, timing is identical to the first POR scenario.
- Glitch/asynchronous check: pulse resetn low for less than one clk period.
  - Outputs clear immediately.
  - A full SYNC_STAGES + HOLD_CYCLES restart follows; no output is released early.
